// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: opcodes,
// FSM state encoding and the default datapath width.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [2:0] MDU_NOP   = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// EX/ID-side connection of the multiply/divide sequencer: instruction issue,
// hazard query and the architectural HI/LO view.
interface mdu_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) ();

    logic             ex_valid;
    logic [2:0]       ex_op;
    logic [WIDTH-1:0] ex_a;
    logic [WIDTH-1:0] ex_b;
    logic             flush;
    logic [2:0]       id_op;
    logic             id_rd_hilo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;

    modport master (
        output ex_valid, ex_op, ex_a, ex_b, flush, id_op, id_rd_hilo,
        input  hi, lo, busy, stall
    );

    modport slave (
        input  ex_valid, ex_op, ex_a, ex_b, flush, id_op, id_rd_hilo,
        output hi, lo, busy, stall
    );

endinterface

// File: rtl/mdu_core.sv
// Radix-2 iterative datapath: shift-add multiply and restoring divide on
// unsigned magnitudes. After WIDTH steps {acc,mq} is the product, or acc/mq
// hold remainder/quotient.
module mdu_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             load_div,
    input  logic             step,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] mq
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q,  mq_d;
    logic [WIDTH-1:0] m_q,   m_d;
    logic             div_q, div_d;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;

    always_comb begin
        acc_d     = acc_q;
        mq_d      = mq_q;
        m_d       = m_q;
        div_d     = div_q;
        add_sum   = {1'b0, acc_q} + {1'b0, m_q};
        rem_shift = {acc_q, mq_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, m_q};

        // mq holds the multiplier for MUL and the dividend/quotient for DIV
        if (load) begin
            acc_d = '0;
            div_d = load_div;
            mq_d  = load_div ? a_mag : b_mag;
            m_d   = load_div ? b_mag : a_mag;
        end else if (step) begin
            if (div_q) begin
                if (!rem_diff[WIDTH]) begin
                    acc_d = rem_diff[WIDTH-1:0];
                    mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rem_shift[WIDTH-1:0];
                    mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                end
            end else if (mq_q[0]) begin
                {acc_d, mq_d} = {add_sum, mq_q[WIDTH-1:1]};
            end else begin
                {acc_d, mq_d} = {1'b0, acc_q, mq_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            mq_q  <= '0;
            m_q   <= '0;
            div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            mq_q  <= mq_d;
            m_q   <= m_d;
            div_q <= div_d;
        end
    end

    assign acc = acc_q;
    assign mq  = mq_q;

endmodule

// File: rtl/mdu_seq.sv
// Multiply/divide sequencer owning HI/LO: accepts ops from EX, runs MUL/DIV
// over WIDTH+1 background cycles and stalls ID when it touches HI/LO.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic   clk,
    input  logic   rst_n,
    mdu_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] hi_q,    hi_d;
    logic [WIDTH-1:0] lo_q,    lo_d;
    logic             busy_q,  busy_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             div0_q,  div0_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;

    logic             signed_op;
    logic             op_div;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             core_load;
    logic             core_step;
    logic [WIDTH-1:0] core_acc;
    logic [WIDTH-1:0] core_mq;

    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_res;
    logic [WIDTH-1:0]   quo_res;
    logic [WIDTH-1:0]   rem_res;

    assign signed_op = (bus.ex_op == MDU_MULT) || (bus.ex_op == MDU_DIV);
    assign op_div    = (bus.ex_op == MDU_DIV)  || (bus.ex_op == MDU_DIVU);
    assign a_mag     = (signed_op && bus.ex_a[WIDTH-1]) ? -bus.ex_a : bus.ex_a;
    assign b_mag     = (signed_op && bus.ex_b[WIDTH-1]) ? -bus.ex_b : bus.ex_b;

    mdu_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (core_load),
        .load_div (op_div),
        .step     (core_step),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .acc      (core_acc),
        .mq       (core_mq)
    );

    // The core's results are unsigned magnitudes; signs are restored in FIX.
    assign prod_mag = {core_acc, core_mq};
    assign prod_res = neg_lo_q ? -prod_mag : prod_mag;
    assign quo_res  = neg_lo_q ? -core_mq  : core_mq;
    assign rem_res  = neg_hi_q ? -core_acc : core_acc;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        div0_d    = div0_q;
        a_raw_d   = a_raw_q;
        core_load = 1'b0;
        core_step = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.ex_valid && !bus.flush) begin
                    if (bus.ex_op == MDU_MTHI) begin
                        hi_d = bus.ex_a;
                    end else if (bus.ex_op == MDU_MTLO) begin
                        lo_d = bus.ex_a;
                    end else if (is_muldiv(bus.ex_op)) begin
                        core_load = 1'b1;
                        state_d   = ST_CALC;
                        cnt_d     = '0;
                        neg_lo_d  = signed_op && (bus.ex_a[WIDTH-1] ^ bus.ex_b[WIDTH-1]);
                        neg_hi_d  = signed_op && bus.ex_a[WIDTH-1];
                        div0_d    = op_div && (bus.ex_b == '0);
                        a_raw_d   = bus.ex_a;
                    end
                end
            end
            ST_CALC: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    core_step = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!bus.flush) begin
                    if (div0_q) begin
                        hi_d = a_raw_q;
                        lo_d = '1;
                    end else if (u_core.div_q) begin
                        hi_d = rem_res;
                        lo_d = quo_res;
                    end else begin
                        {hi_d, lo_d} = prod_res;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            a_raw_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            div0_q   <= div0_d;
            a_raw_q  <= a_raw_d;
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = busy_q;
    assign bus.stall = busy_q && (bus.id_rd_hilo || (bus.id_op != MDU_NOP));

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: vector table with scoreboard plus
// hand-written stall, flush, protocol-error and async-reset sequences.
module tb_mdu_seq;
    import mdu_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sb[$];
    vec_t vecs[15];

    mdu_if #(.WIDTH(32)) mif ();

    mdu_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input exp_t e);
        @(negedge clk);
        mif.ex_valid = 1'b1;
        mif.ex_op    = op;
        mif.ex_a     = a;
        mif.ex_b     = b;
        sb.push_back(e);
        @(negedge clk);
        mif.ex_valid = 1'b0;
        mif.ex_op    = MDU_NOP;
    endtask

    // Waits out the operation (bounded), then compares latency and HI/LO.
    task automatic checkOutput(input string tag);
        int   cycles;
        exp_t e;
        cycles = 0;
        while (mif.busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            checkEq({tag, " scoreboard"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            checkEq({tag, " cycles"}, 64'(cycles), 64'(e.cycles));
            checkEq({tag, " hi"}, {32'd0, mif.hi}, {32'd0, e.hi});
            checkEq({tag, " lo"}, {32'd0, mif.lo}, {32'd0, e.lo});
            checkEq({tag, " stall_after"}, {63'd0, mif.stall}, 64'd0);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t          e;
        longint        sa, sbv, p, q, r;
        longint unsigned ua, ub, up;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        e.cycles = 33;
        e.hi = '0;
        e.lo = '0;
        case (op)
            MDU_MULT:  begin p = sa * sbv; {e.hi, e.lo} = p; end
            MDU_MULTU: begin up = ua * ub; {e.hi, e.lo} = up; end
            MDU_DIV:   begin q = sa / sbv; r = sa % sbv; e.lo = q[31:0]; e.hi = r[31:0]; end
            MDU_DIVU:  begin e.lo = 32'(ua / ub); e.hi = 32'(ua % ub); end
            default:   ;
        endcase
        return e;
    endfunction

    initial begin
        exp_t        e;
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        int          cyc, stall_cnt;

        total = 0;
        bad   = 0;
        vecs[0]  = '{MDU_MTLO,  32'h12345678, 32'h0,        32'h00000000, 32'h12345678, 0};
        vecs[1]  = '{MDU_MTHI,  32'hCAFEBABE, 32'h0,        32'hCAFEBABE, 32'h12345678, 0};
        vecs[2]  = '{MDU_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 33};
        vecs[3]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
        vecs[4]  = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[5]  = '{MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33};
        vecs[6]  = '{MDU_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 33};
        vecs[7]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[8]  = '{MDU_DIV,   32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 32'hFFFFFFFF, 33};
        vecs[9]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};
        vecs[10] = '{MDU_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 33};
        vecs[11] = '{MDU_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 33};
        vecs[12] = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
        vecs[13] = '{3'd7,      32'h11111111, 32'h22222222, 32'd1,        32'hFFFFFFFD, 0};
        vecs[14] = '{MDU_MULTU, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        33};

        mif.ex_valid   = 1'b0;
        mif.ex_op      = MDU_NOP;
        mif.ex_a       = '0;
        mif.ex_b       = '0;
        mif.flush      = 1'b0;
        mif.id_op      = MDU_NOP;
        mif.id_rd_hilo = 1'b1;
        rst_n          = 1'b0;

        repeat (2) @(negedge clk);
        checkEq("reset hi", {32'd0, mif.hi}, 64'd0);
        checkEq("reset lo", {32'd0, mif.lo}, 64'd0);
        checkEq("reset busy", {63'd0, mif.busy}, 64'd0);
        checkEq("reset stall", {63'd0, mif.stall}, 64'd0);
        rst_n = 1'b1;

        $display("[TB] vector table");
        for (int i = 0; i < 15; i++) begin
            e.hi = vecs[i].hi;
            e.lo = vecs[i].lo;
            e.cycles = vecs[i].cycles;
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, e);
            checkOutput($sformatf("vec%0d", i));
        end

        $display("[TB] random vectors");
        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(1, 4));
            ra  = $urandom;
            rb  = $urandom;
            if (rb == 32'd0) rb = 32'd3;
            if (rop == MDU_DIV && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd5;
            applyStimulus(rop, ra, rb, model(rop, ra, rb));
            checkOutput($sformatf("rnd%0d op%0d", i, rop));
        end

        // MULT 6*-5 with mfhi in ID from the next cycle; cycle 5/6 probe id_op path.
        $display("[TB] stall sequence");
        @(negedge clk);
        mif.id_rd_hilo = 1'b1;
        #1;
        checkEq("stall idle", {63'd0, mif.stall}, 64'd0);
        mif.ex_valid = 1'b1;
        mif.ex_op    = MDU_MULT;
        mif.ex_a     = 32'd6;
        mif.ex_b     = 32'hFFFFFFFB;
        @(negedge clk);
        mif.ex_valid = 1'b0;
        mif.ex_op    = MDU_NOP;
        cyc = 0;
        stall_cnt = 0;
        while (mif.busy && cyc < 100) begin
            cyc++;
            mif.id_rd_hilo = (cyc == 5 || cyc == 6) ? 1'b0 : 1'b1;
            mif.id_op      = (cyc == 5) ? MDU_MULT : MDU_NOP;
            #1;
            if (cyc == 5) checkEq("stall id_op", {63'd0, mif.stall}, 64'd1);
            else if (cyc == 6) checkEq("stall none", {63'd0, mif.stall}, 64'd0);
            else if (mif.stall) stall_cnt++;
            @(negedge clk);
        end
        mif.id_rd_hilo = 1'b1;
        mif.id_op      = MDU_NOP;
        #1;
        checkEq("stall busy cycles", 64'(cyc), 64'd33);
        checkEq("stall count", 64'(stall_cnt), 64'd31);
        checkEq("stall released", {63'd0, mif.stall}, 64'd0);
        checkEq("stall mfhi hi", {32'd0, mif.hi}, 64'h00000000FFFFFFFF);
        checkEq("stall mflo lo", {32'd0, mif.lo}, 64'h00000000FFFFFFE2);

        $display("[TB] flush sequence");
        @(negedge clk);
        mif.ex_valid = 1'b1;
        mif.ex_op    = MDU_MULT;
        mif.ex_a     = 32'd2;
        mif.ex_b     = 32'd3;
        @(negedge clk);
        mif.ex_valid = 1'b0;
        mif.ex_op    = MDU_NOP;
        repeat (9) @(negedge clk);
        mif.flush = 1'b1;
        @(negedge clk);
        mif.flush = 1'b0;
        checkEq("flush busy drop", {63'd0, mif.busy}, 64'd0);
        cyc = 0;
        for (int k = 0; k < 40; k++) begin
            if (mif.busy) cyc++;
            @(negedge clk);
        end
        checkEq("flush no rebusy", 64'(cyc), 64'd0);
        checkEq("flush hi kept", {32'd0, mif.hi}, 64'h00000000FFFFFFFF);
        checkEq("flush lo kept", {32'd0, mif.lo}, 64'h00000000FFFFFFE2);

        mif.ex_valid = 1'b1;
        mif.ex_op    = MDU_MTHI;
        mif.ex_a     = 32'h00000055;
        mif.flush    = 1'b1;
        @(negedge clk);
        mif.ex_op    = MDU_MULT;
        @(negedge clk);
        mif.ex_valid = 1'b0;
        mif.ex_op    = MDU_NOP;
        mif.flush    = 1'b0;
        checkEq("flush idle mthi", {32'd0, mif.hi}, 64'h00000000FFFFFFFF);
        checkEq("flush idle busy", {63'd0, mif.busy}, 64'd0);

        // MTLO pulsed while busy must be ignored; HI/LO hold old values mid-op.
        $display("[TB] issue while busy");
        e.hi = 32'd0;
        e.lo = 32'd12;
        e.cycles = 33;
        applyStimulus(MDU_MULT, 32'd3, 32'd4, e);
        repeat (4) @(negedge clk);
        mif.ex_valid = 1'b1;
        mif.ex_op    = MDU_MTLO;
        mif.ex_a     = 32'h0000DEAD;
        @(negedge clk);
        mif.ex_valid = 1'b0;
        mif.ex_op    = MDU_NOP;
        repeat (10) @(negedge clk);
        checkEq("mid hi hold", {32'd0, mif.hi}, 64'h00000000FFFFFFFF);
        checkEq("mid lo hold", {32'd0, mif.lo}, 64'h00000000FFFFFFE2);
        sb[0].cycles = 18;
        checkOutput("busy issue");

        $display("[TB] async reset mid-divide");
        e.hi = 32'd0;
        e.lo = 32'd0;
        e.cycles = 33;
        @(negedge clk);
        mif.ex_valid = 1'b1;
        mif.ex_op    = MDU_DIV;
        mif.ex_a     = 32'd100;
        mif.ex_b     = 32'd3;
        @(negedge clk);
        mif.ex_valid = 1'b0;
        mif.ex_op    = MDU_NOP;
        repeat (19) @(negedge clk);
        checkEq("pre-reset busy", {63'd0, mif.busy}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkEq("async hi", {32'd0, mif.hi}, 64'd0);
        checkEq("async lo", {32'd0, mif.lo}, 64'd0);
        checkEq("async busy", {63'd0, mif.busy}, 64'd0);
        checkEq("async stall", {63'd0, mif.stall}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        e.hi = 32'h0000ABCD;
        e.lo = 32'd0;
        e.cycles = 0;
        applyStimulus(MDU_MTHI, 32'h0000ABCD, 32'd0, e);
        checkOutput("post-reset mthi");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
